// File: rtl/srrc_rx_slicer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : srrc_rx_slicer
// Brief   : 4-ASK symbol picker/slicer with adaptive reference and MER error
// Revision: 1.0
// ============================================================================
module srrc_rx_slicer #(
    parameter int                 LOG2_N   = 10,
    parameter logic signed [17:0] REF_INIT = 18'sd65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic [1:0]         phase,
    input  logic signed [17:0] in,
    output logic               sym_valid,
    output logic [1:0]         sym_out,
    output logic signed [17:0] dec_level,
    output logic signed [17:0] err,
    output logic signed [17:0] ref_level,
    output logic [39:0]        err_sq_acc,
    output logic               acc_valid
);

    localparam int c_ACC_W = 18 + LOG2_N;

    function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
        if (v > 19'sd131071)
            return 18'sd131071;
        else if (v < -19'sd131072)
            return 18'sh20000;
        else
            return v[17:0];
    endfunction

    logic [1:0]               cnt_q, cnt_d;
    logic                     cap_q;
    logic signed [17:0]       x_q;
    logic                     sym_valid_q;
    logic [1:0]               sym_q;
    logic signed [17:0]       dec_q;
    logic signed [17:0]       err_q;
    logic [17:0]              abs_q;
    logic [LOG2_N-1:0]        sym_cnt_q;
    logic [c_ACC_W-1:0]       abs_acc_q;
    logic [39:0]              sq_acc_q;
    logic signed [17:0]       ref_q;
    logic [39:0]              err_sq_q;
    logic                     acc_valid_q;

    logic [1:0]               w_phase_idx;
    logic                     w_capture;
    logic signed [18:0]       w_x19, w_ref19, w_half19, w_big19;
    logic signed [17:0]       w_half;
    logic [1:0]               w_sym;
    logic signed [18:0]       w_dec19;
    logic signed [17:0]       w_dec;
    logic signed [18:0]       w_diff;
    logic [17:0]              w_abs;
    logic signed [35:0]       w_prod;
    logic [39:0]              w_sq_term;
    logic [c_ACC_W-1:0]       w_abs_sum;
    logic [39:0]              w_sq_sum;
    logic [c_ACC_W-1:0]       w_mean;
    logic signed [17:0]       w_ref_new;
    logic                     w_blk_end;

    // Sample 0 of a symbol is the one flagged by sym_clk_en; later ones follow cnt.
    assign w_phase_idx = sym_clk_en ? 2'd0 : cnt_q + 2'd1;
    assign w_capture   = sam_clk_en && (w_phase_idx == phase);

    always_comb begin
        cnt_d = cnt_q;
        if (sym_clk_en)
            cnt_d = 2'd0;
        else if (sam_clk_en)
            cnt_d = cnt_q + 2'd1;
    end

    assign w_half   = ref_q >>> 1;
    assign w_x19    = {x_q[17], x_q};
    assign w_ref19  = {ref_q[17], ref_q};
    assign w_half19 = {w_half[17], w_half};
    assign w_big19  = w_ref19 + w_half19;

    always_comb begin
        w_sym   = 2'b10;
        w_dec19 = w_half19;
        if (w_x19 >= w_ref19) begin
            w_sym   = 2'b11;
            w_dec19 = w_big19;
        end else if (!x_q[17]) begin
            w_sym   = 2'b10;
            w_dec19 = w_half19;
        end else if (w_x19 >= -w_ref19) begin
            w_sym   = 2'b01;
            w_dec19 = -w_half19;
        end else begin
            w_sym   = 2'b00;
            w_dec19 = -w_big19;
        end
    end

    assign w_dec  = sat18(w_dec19);
    assign w_diff = w_x19 - {w_dec[17], w_dec};
    // Two's-complement negate of -131072 yields bit pattern 0x20000 = 131072 unsigned.
    assign w_abs  = x_q[17] ? (~x_q + 18'd1) : x_q;

    assign w_prod    = err_q * err_q;
    assign w_sq_term = 40'(w_prod >>> 17);
    assign w_abs_sum = abs_acc_q + c_ACC_W'(abs_q);
    assign w_sq_sum  = sq_acc_q + w_sq_term;
    assign w_mean    = w_abs_sum >> LOG2_N;
    assign w_ref_new = (|w_mean[c_ACC_W-1:17]) ? 18'sd131071 : w_mean[17:0];
    assign w_blk_end = sym_valid_q && (sym_cnt_q == '1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= 2'd0;
            cap_q       <= 1'b0;
            x_q         <= '0;
            sym_valid_q <= 1'b0;
            sym_q       <= 2'b00;
            dec_q       <= '0;
            err_q       <= '0;
            abs_q       <= '0;
            sym_cnt_q   <= '0;
            abs_acc_q   <= '0;
            sq_acc_q    <= '0;
            ref_q       <= REF_INIT;
            err_sq_q    <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cap_q       <= w_capture;
            sym_valid_q <= cap_q;
            acc_valid_q <= w_blk_end;
            if (w_capture)
                x_q <= in;
            if (cap_q) begin
                sym_q <= w_sym;
                dec_q <= w_dec;
                err_q <= sat18(w_diff);
                abs_q <= w_abs;
            end
            if (sym_valid_q) begin
                sym_cnt_q <= sym_cnt_q + LOG2_N'(1);
                if (w_blk_end) begin
                    ref_q     <= w_ref_new;
                    err_sq_q  <= w_sq_sum;
                    abs_acc_q <= '0;
                    sq_acc_q  <= '0;
                end else begin
                    abs_acc_q <= w_abs_sum;
                    sq_acc_q  <= w_sq_sum;
                end
            end
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym_out    = sym_q;
    assign dec_level  = dec_q;
    assign err        = err_q;
    assign ref_level  = ref_q;
    assign err_sq_acc = err_sq_q;
    assign acc_valid  = acc_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_srrc_rx_slicer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_srrc_rx_slicer
// Brief   : Randomized self-checking bench with a symbol-level reference model
// Revision: 1.0
// ============================================================================
module tb_srrc_rx_slicer;

    localparam int LOG2_N   = 2;
    localparam int NBLK     = 1 << LOG2_N;
    localparam int REF_INIT = 65536;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sam_clk_en = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic [1:0]         phase = 2'd0;
    logic signed [17:0] in_s = '0;
    logic               sym_valid;
    logic [1:0]         sym_out;
    logic signed [17:0] dec_level;
    logic signed [17:0] err;
    logic signed [17:0] ref_level;
    logic [39:0]        err_sq_acc;
    logic               acc_valid;

    srrc_rx_slicer #(.LOG2_N(LOG2_N), .REF_INIT(18'sd65536)) dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .phase      (phase),
        .in         (in_s),
        .sym_valid  (sym_valid),
        .sym_out    (sym_out),
        .dec_level  (dec_level),
        .err        (err),
        .ref_level  (ref_level),
        .err_sq_acc (err_sq_acc),
        .acc_valid  (acc_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    typedef struct { int cyc; int sym; int dec; int err; int ref_l; longint esq; } sym_rec_t;
    typedef struct { int cyc; int ref_l; longint esq; } acc_rec_t;
    sym_rec_t sym_exp[$];
    acc_rec_t acc_exp[$];

    int     m_ref = REF_INIT;
    longint m_abs = 0, m_sq = 0, m_esq = 0;
    int     m_n = 0;
    bit     mon_en = 1'b0;
    int     last_phase = -1;

    function automatic longint clamp18(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    // Symbol-level model: one call per picked sample, in symbol order.
    task automatic model_symbol(input int x, input int pcyc);
        longint r, a, d, e, ax, mean;
        int s;
        sym_rec_t sr;
        acc_rec_t ar;
        r = m_ref;
        a = r / 2;
        if (x >= r)       begin s = 3; d = a + r;    end
        else if (x >= 0)  begin s = 2; d = a;        end
        else if (x >= -r) begin s = 1; d = -a;       end
        else              begin s = 0; d = -(a + r); end
        d  = clamp18(d);
        e  = clamp18(x - d);
        ax = (x < 0) ? -x : x;
        sr.cyc = pcyc + 2; sr.sym = s; sr.dec = int'(d); sr.err = int'(e);
        sr.ref_l = m_ref; sr.esq = m_esq;
        sym_exp.push_back(sr);
        m_abs += ax;
        m_sq  += (e * e) / 131072;
        m_n++;
        if (m_n == NBLK) begin
            mean  = m_abs / NBLK;
            m_ref = (mean > 131071) ? 131071 : int'(mean);
            m_esq = m_sq;
            ar.cyc = pcyc + 3; ar.ref_l = m_ref; ar.esq = m_esq;
            acc_exp.push_back(ar);
            m_abs = 0; m_sq = 0; m_n = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sym_exp.size() > 0 && sym_exp[0].cyc < cyc) begin
                chk("sym_valid_missing", cyc, sym_exp[0].cyc);
                void'(sym_exp.pop_front());
            end
            if (acc_exp.size() > 0 && acc_exp[0].cyc < cyc) begin
                chk("acc_valid_missing", cyc, acc_exp[0].cyc);
                void'(acc_exp.pop_front());
            end
            if (sym_valid) begin
                if (sym_exp.size() == 0) begin
                    chk("sym_valid_unexpected", 1, 0);
                end else begin
                    sym_rec_t r;
                    r = sym_exp.pop_front();
                    chk("sym_valid_cycle", cyc, r.cyc);
                    chk("sym_out", sym_out, r.sym);
                    chk("dec_level", dec_level, r.dec);
                    chk("err", err, r.err);
                    chk("ref_level_hold", ref_level, r.ref_l);
                    chk("err_sq_acc_hold", err_sq_acc, r.esq);
                end
            end
            if (acc_valid) begin
                if (acc_exp.size() == 0) begin
                    chk("acc_valid_unexpected", 1, 0);
                end else begin
                    acc_rec_t r;
                    r = acc_exp.pop_front();
                    chk("acc_valid_cycle", cyc, r.cyc);
                    chk("ref_level", ref_level, r.ref_l);
                    chk("err_sq_acc", err_sq_acc, r.esq);
                end
            end
        end
    end

    function automatic int rnd_full();
        logic signed [17:0] t;
        t = 18'($urandom);
        return int'(t);
    endfunction

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sam_clk_en = 1'b0;
            sym_clk_en = 1'b0;
            in_s       = 18'($urandom);
        end
    endtask

    task automatic send_symbol(input int s [4], input int ph);
        if (ph != last_phase) drive_idle(3);
        last_phase = ph;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            sam_clk_en = 1'b1;
            sym_clk_en = (j == 0);
            phase      = 2'(ph);
            in_s       = 18'(s[j]);
            if (j == ph) model_symbol(s[j], cyc);
            drive_idle(int'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_x(input int x, input int ph);
        int v [4];
        for (int j = 0; j < 4; j++) v[j] = rnd_full();
        v[ph] = x;
        send_symbol(v, ph);
    endtask

    task automatic do_reset();
        drive_idle(5);
        chk("sym_pending_at_reset", sym_exp.size(), 0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            sam_clk_en = 1'($urandom);
            sym_clk_en = 1'($urandom);
            phase      = 2'($urandom);
            in_s       = 18'($urandom);
            @(posedge clk); #1;
            chk("rst_sym_valid", sym_valid, 0);
            chk("rst_acc_valid", acc_valid, 0);
            chk("rst_sym_out", sym_out, 0);
            chk("rst_dec_level", dec_level, 0);
            chk("rst_err", err, 0);
            chk("rst_ref_level", ref_level, REF_INIT);
            chk("rst_err_sq_acc", err_sq_acc, 0);
        end
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        reset      = 1'b1;
        sym_exp.delete();
        acc_exp.delete();
        m_ref = REF_INIT; m_abs = 0; m_sq = 0; m_esq = 0; m_n = 0;
        last_phase = -1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v [4];
        int t;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        do_reset();

        // Phase select on a fixed sample pattern
        v = '{10000, 20000, 98304, 30000};
        send_symbol(v, 2);
        send_symbol(v, 0);
        drive_idle(5);
        chk("phase0_err_held", err, -22768);

        // Thresholds at ref 65536
        do_reset();
        send_x(0, 1);
        send_x(65536, 1);
        send_x(-65536, 1);
        send_x(-65537, 1);
        do_reset();
        send_x(40000, 3);
        drive_idle(5);
        chk("thr_40000_err", err, 7232);

        // Block update
        do_reset();
        send_x(24576, 2);
        send_x(-24576, 2);
        send_x(73728, 2);
        send_x(-73728, 2);
        drive_idle(5);
        chk("blk_ref_level", ref_level, 49152);
        chk("blk_err_sq_acc", err_sq_acc, 10240);
        send_x(40000, 2);
        drive_idle(5);
        chk("blk_next_err", err, 15424);

        // Saturation at full-scale negative input
        do_reset();
        send_x(-131072, 1);
        drive_idle(5);
        chk("sat_err", err, -32768);
        repeat (3) send_x(-131072, 1);
        drive_idle(5);
        chk("sat_ref_level", ref_level, 131071);

        // Reset mid-block
        do_reset();
        send_x(rnd_full(), 0);
        send_x(rnd_full(), 0);
        do_reset();
        repeat (4) send_x(49152, 3);
        drive_idle(5);
        chk("midrst_ref_level", ref_level, 49152);

        // Randomized symbols, phases and values
        do_reset();
        for (int k = 0; k < 48; k++) begin
            int ph;
            ph = (($urandom_range(0, 3) == 0) || k == 0) ? int'($urandom_range(0, 3)) : last_phase;
            case ($urandom_range(0, 4))
                0: t = rnd_full();
                1: t = m_ref + int'($urandom_range(0, 4)) - 2;
                2: t = -m_ref + int'($urandom_range(0, 4)) - 2;
                3: t = int'($urandom_range(0, 2)) - 1;
                default: t = ($urandom_range(0, 1) == 1) ? 131071 : -131072;
            endcase
            if (t > 131071) t = 131071;
            if (t < -131072) t = -131072;
            send_x(t, ph);
        end
        drive_idle(8);
        chk("sym_pending_end", sym_exp.size(), 0);
        chk("acc_pending_end", acc_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srrc_rx_slicer.md
Name: srrc_rx_slicer

Overview:
- Receive-side counterpart to the SRRC transmit filter.
- Takes the 4-ASK matched-filter output at sample rate (4 samples/symbol) and picks one sample per symbol at a selectable phase.
- Slices each picked sample into a 2-bit symbol decision using an adaptively tracked reference level.
- Produces the slicer error and a block-accumulated squared error, used downstream for MER measurement.

Parameters:
- LOG2_N, 10, log2 of symbols per averaging block (ref level and error accumulation).
- REF_INIT, 18'sd65536, reference level (1s17 format) used until the first block completes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- sam_clk_en  in  1  sample-rate enable, one clk wide
- sym_clk_en  in  1  symbol-rate enable, coincident with every 4th sam_clk_en
- phase  in  2  sample index within the symbol to decide on (0 = the sym_clk_en sample)
- in  in  18  signed 1s17 matched-filter output, valid on sam_clk_en
- sym_valid  out  1  one-clk pulse, decision outputs updated
- sym_out  out  2  decision: 00=-3, 01=-1, 10=+1, 11=+3
- dec_level  out  18  signed ideal level of the decision
- err  out  18  signed in_sample - dec_level, saturated
- ref_level  out  18  current reference level (mean |x|)
- err_sq_acc  out  40  sum of squared error over the last completed block
- acc_valid  out  1  one-clk pulse when ref_level and err_sq_acc update

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - all outputs to 0, except ref_level = REF_INIT;
  - phase counter, symbol counter and accumulators to 0.
- Reset mid-block discards partial accumulations.
- Phase counter cnt[1:0]:
  - set to 0 on sym_clk_en;
  - else incremented on sam_clk_en;
  - wraps 3->0.
- Capture: on a clk where sam_clk_en==1 and the phase index equals phase, register in into x.
  - The phase index is 0 when sym_clk_en is high, else cnt+1.
  - Exactly one capture per symbol.
- Decision is made one clk after capture, using the ref_level current at that time. Let r = ref_level, a = r>>>1.
  - x >= r: +3, dec_level = a + r
  - 0 <= x < r: +1, dec_level = a
  - -r <= x < 0: -1, dec_level = -a
  - x < -r: -3, dec_level = -(a + r)
- Ties resolve upward as listed: x==0 gives +1, x==r gives +3, x==-r gives -1.
- Error: err = x - dec_level, computed at 19 bits and saturated to [-131072, 131071].
- Output timing:
  - sym_out, dec_level and err are registered and sym_valid pulses 2 clks after the capture clk.
  - These outputs hold their values between pulses.
- Accumulation, on each sym_valid:
  - abs_acc (18+LOG2_N bits, unsigned) += |x|, where |-131072| is 131072;
  - sq_acc (40 bits) += (err*err)>>>17, i.e. the 36-bit product with the 17 fractional bits dropped;
  - symbol counter (LOG2_N bits) increments.
- Block end, on the sym_valid where the counter wraps to 0, one clk later:
  - ref_level = abs_acc >> LOG2_N, saturated to 131071;
  - err_sq_acc = sq_acc including the final symbol;
  - acc_valid pulses;
  - abs_acc and sq_acc clear.
- The new ref_level applies to the next decision.
- A block-end update and a new decision on the same clk are not possible: minimum symbol spacing is 4 clks.
- Enables are assumed well-formed. If sym_clk_en arrives off-cadence, cnt resynchronises to 0 immediately and no extra capture is generated beyond the phase match.

Test Plan:
- Bench parameters for all scenarios: LOG2_N=2, REF_INIT=65536.
- Reset: hold reset=0 for 3 clks with random inputs -> all outputs 0, ref_level=65536, no pulses. Release -> first sym_valid only after a capture + 2 clks.
- Phase select: per symbol, drive samples 10000, 20000, 98304, 30000 with phase=2 -> sym_out=11, dec_level=98304, err=0. Repeat with phase=0 -> sym_out=10, dec_level=32768, err=-22768.
- Decision thresholds: x = 0, 65536, -65536, -65537, 40000 -> sym_out = 10, 11, 01, 00, 10. The last gives err=7232.
- Block update: x = 24576, -24576, 73728, -73728 on four symbols:
  - decisions are 10, 01, 11, 00;
  - errs are -8192, 8192, -24576, 24576;
  - acc_valid pulses 1 clk after the 4th sym_valid, with err_sq_acc=10240 and ref_level=49152.
  - A following x=40000 then gives sym_out=10, dec_level=24576, err=15424.
- Saturation: ref_level=65536, x=-131072 -> sym_out=00, dec_level=-98304, err=-32768. Also check that |x| accumulates 131072 without wrapping.
- Reset mid-block: apply reset after 2 of 4 symbols, then 4 symbols of x=49152 -> ref_level becomes 49152 only after those 4. Also confirm err_sq_acc=0 before that point.
